// File: rtl/accum_to_posit16_es2.sv
// Four-stage encoder from serialized accumulator form {sgn, scale, fraction, inf, zero}
// to a posit<N,2> word with round-to-nearest-even and an inexact flag.
module accum_to_posit16_es2 #(
  parameter int unsigned N     = 16,
  parameter int unsigned FBITS = 128,
  parameter int unsigned SBITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SBITS+FBITS+2:0]   in1,
  input  logic                     truncated_in,
  output logic [N-1:0]             result,
  output logic                     done,
  output logic                     inexact
);

  localparam int unsigned SMAX = 4 * (N - 2);
  localparam int unsigned RW   = N + 2 + FBITS;

  localparam logic signed [SBITS-1:0] SmaxPos = SBITS'(SMAX);
  localparam logic signed [SBITS-1:0] SmaxNeg = SBITS'(-int'(SMAX));
  localparam logic [N-1:0]            MaxPos  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]            MinPos  = N'(1);
  localparam logic [N-1:0]            NaR     = {1'b1, {(N-1){1'b0}}};

  // Input field split
  logic                    sgn_in;
  logic signed [SBITS-1:0] scale_in;
  logic [FBITS-1:0]        frac_in;
  logic                    inf_in, zero_in;

  assign sgn_in   = in1[SBITS+FBITS+2];
  assign scale_in = in1[SBITS+FBITS+1 -: SBITS];
  assign frac_in  = in1[FBITS+1:2];
  assign inf_in   = in1[1];
  assign zero_in  = in1[0];

  // Valid chain (reset) and data registers (free-running)
  logic v1_q, v2_q, v3_q;
  logic v1_d;

  logic                    sgn1_q, inf1_q, zero1_q, trunc1_q, ovf1_q, unf1_q;
  logic signed [SBITS-1:0] k1_q;
  logic [1:0]              e1_q;
  logic [FBITS-1:0]        frac1_q;

  logic                    sgn2_q, inf2_q, zero2_q, ovf2_q, unf2_q, g2_q, s2_q;
  logic [N-2:0]            kept2_q;

  logic                    sgn3_q, inf3_q, zero3_q, inex3_q;
  logic [N-1:0]            mag3_q;

  logic [N-1:0]            result_d;
  logic                    inexact_d;

  // Start of X or 0 both yield an empty slot
  always_comb begin
    v1_d = 1'b0;
    if (start) v1_d = 1'b1;
  end

  // S2: regime + exponent + fraction, left-aligned, then split into kept/guard/sticky
  logic [SBITS:0]  rlen;
  logic [RW-1:0]   tail, shifted, regime, word;
  logic [N-2:0]    kept2_d;
  logic            g2_d, s2_d;

  always_comb begin
    if (!k1_q[SBITS-1]) begin
      rlen = {1'b0, k1_q} + (SBITS+1)'(2);
    end else begin
      rlen = (SBITS+1)'(1) - {1'b1, k1_q};
    end
    tail    = {e1_q, frac1_q, {N{1'b0}}};
    shifted = tail >> rlen;
    if (!k1_q[SBITS-1]) begin
      regime = ~({RW{1'b1}} >> (rlen - 1'b1));
    end else begin
      regime = {1'b1, {(RW-1){1'b0}}} >> (rlen - 1'b1);
    end
    word    = shifted | regime;
    kept2_d = word[RW-1 -: N-1];
    g2_d    = word[RW-N];
    s2_d    = (|word[RW-N-1:0]) | trunc1_q;
  end

  // S3: round-to-nearest-even with clamp away from 0 and NaR
  logic [N-1:0] mag3_d;
  logic         inex3_d, inc;

  always_comb begin
    inc    = g2_q & (kept2_q[0] | s2_q);
    mag3_d = {1'b0, kept2_q} + N'(inc);
    if (mag3_d == '0)  mag3_d = MinPos;
    if (mag3_d[N-1])   mag3_d = MaxPos;
    if (ovf2_q)        mag3_d = MaxPos;
    else if (unf2_q)   mag3_d = MinPos;
    inex3_d = g2_q | s2_q | ovf2_q | unf2_q;
  end

  // S4: sign and specials; inf outranks zero
  always_comb begin
    result_d  = sgn3_q ? (~mag3_q + N'(1)) : mag3_q;
    inexact_d = inex3_q;
    if (inf3_q) begin
      result_d  = NaR;
      inexact_d = 1'b0;
    end else if (zero3_q) begin
      result_d  = '0;
      inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      inexact <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      done    <= v3_q;
      result  <= result_d;
      inexact <= inexact_d;
    end
  end

  always_ff @(posedge clk) begin
    sgn1_q   <= sgn_in;
    inf1_q   <= inf_in;
    zero1_q  <= zero_in;
    trunc1_q <= truncated_in;
    ovf1_q   <= scale_in > SmaxPos;
    unf1_q   <= scale_in < SmaxNeg;
    k1_q     <= scale_in >>> 2;
    e1_q     <= scale_in[1:0];
    frac1_q  <= frac_in;

    sgn2_q   <= sgn1_q;
    inf2_q   <= inf1_q;
    zero2_q  <= zero1_q;
    ovf2_q   <= ovf1_q;
    unf2_q   <= unf1_q;
    kept2_q  <= kept2_d;
    g2_q     <= g2_d;
    s2_q     <= s2_d;

    sgn3_q   <= sgn2_q;
    inf3_q   <= inf2_q;
    zero3_q  <= zero2_q;
    mag3_q   <= mag3_d;
    inex3_q  <= inex3_d;
  end

endmodule

// File: tb/tb_accum_to_posit16_es2.sv
// Bench for accum_to_posit16_es2: directed corner vectors, reset abort, then random traffic
// against a bit-list posit reference model with a due-cycle scoreboard.
module tb_accum_to_posit16_es2;

  localparam int N     = 16;
  localparam int FBITS = 128;
  localparam int SBITS = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [SBITS+FBITS+2:0] in1;
  logic                   truncated_in;
  logic [N-1:0]           result;
  logic                   done;
  logic                   inexact;

  accum_to_posit16_es2 #(.N(N), .FBITS(FBITS), .SBITS(SBITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in1          (in1),
    .truncated_in (truncated_in),
    .result       (result),
    .done         (done),
    .inexact      (inexact)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [15:0] res;
    logic        inex;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: write out the posit bit string one bit at a time, then cut and round
  function automatic void model(input logic sgn, input int scale, input logic [127:0] frac,
                                input logic inf, input logic zero, input logic trunc,
                                output logic [15:0] res, output logic inex);
    int   k, e, kept, mag;
    bit   q[$];
    logic g, s;
    if (inf) begin
      res = 16'h8000; inex = 1'b0; return;
    end
    if (zero) begin
      res = 16'h0000; inex = 1'b0; return;
    end
    if (scale > 56) begin
      mag = 32767; inex = 1'b1;
    end else if (scale < -56) begin
      mag = 1; inex = 1'b1;
    end else begin
      e = scale & 3;
      k = (scale - e) / 4;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 127; i >= 0; i--) q.push_back(frac[i]);
      kept = 0;
      for (int i = 0; i < 15; i++) kept = kept * 2 + int'(q[i]);
      g = q[15];
      s = trunc;
      for (int i = 16; i < q.size(); i++) s = s | q[i];
      mag = kept + ((g && ((kept % 2 == 1) || s)) ? 1 : 0);
      if (mag < 1) mag = 1;
      if (mag > 32767) mag = 32767;
      inex = g | s;
    end
    res = sgn ? 16'((65536 - mag) % 65536) : 16'(mag);
  endfunction

  // One clock: drive, advance, then check whatever is due this cycle
  task automatic step(input logic st, input logic sgn, input int scale, input logic [127:0] frac,
                      input logic inf, input logic zero, input logic trunc,
                      input logic use_exp, input logic [15:0] eres, input logic einex);
    exp_t x;
    x.due = 0; x.res = '0; x.inex = 1'b0;
    start        = st;
    in1          = {sgn, SBITS'(scale), frac, inf, zero};
    truncated_in = trunc;
    if (st) begin
      model(sgn, scale, frac, inf, zero, trunc, x.res, x.inex);
      if (use_exp) begin
        x.res  = eres;
        x.inex = einex;
      end
      x.due = cyc + 4;
      expq.push_back(x);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      x = expq.pop_front();
      check("done", 32'(done), 32'd1);
      check("result", 32'(result), 32'(x.res));
      check("inexact", 32'(inexact), 32'(x.inex));
    end else begin
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [127:0] f0, half, tie, rf;

  initial begin
    f0   = '0;
    half = {1'b1, 127'b0};
    tie  = 128'b1 << 116;
    rst = 1'b1; start = 1'b0; in1 = '0; truncated_in = 1'b0;
    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_inexact", 32'(inexact), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corners with hand-derived expectations
    step(1'b1, 1'b0,   0, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0);
    step(1'b1, 1'b1,   0, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'hC000, 1'b0);
    step(1'b1, 1'b0,   1, half, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4C00, 1'b0);
    step(1'b1, 1'b0,  57, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    step(1'b1, 1'b1, -60, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0,   0, tie,  1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b1);
    step(1'b1, 1'b0,   0, tie,  1'b0, 1'b0, 1'b1, 1'b1, 16'h4001, 1'b1);
    step(1'b1, 1'b0,   5, half, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b1, 1'b1,   5, half, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0);
    step(1'b1, 1'b0,  56, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
    step(1'b1, 1'b0, -56, f0,   1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    idle(6);

    // Back-to-back run with distinct scales
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'(i & 1), i * 7 - 30, half >> i, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(6);

    // Reset in mid-flight drops everything in the pipe
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, i + 3, half, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_inexact", 32'(inexact), 32'h0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    step(1'b1, 1'b0, 2, half, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(6);

    // Random traffic, with tie-prone fractions mixed in
    for (int i = 0; i < 300; i++) begin
      rf = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rf[100:0] = '0;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 150)) - 75,
           rf, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
